// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a 4x4 systolic array.
// Holds A/B banks and streams them row/column-skewed after a clear pulse.
module systolic_feeder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_1,
  output logic [DATA_WIDTH-1:0] left_o_2,
  output logic [DATA_WIDTH-1:0] left_o_3,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3,
  output logic                  clr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, DONE
  } state_t;

  state_t state;
  logic [2:0] cnt;
  logic [2:0] t_nxt;

  logic [DATA_WIDTH-1:0] a_q [16];
  logic [DATA_WIDTH-1:0] b_q [16];
  logic [DATA_WIDTH-1:0] left_q [4];
  logic [DATA_WIDTH-1:0] up_q [4];
  logic [DATA_WIDTH-1:0] left_d [4];
  logic [DATA_WIDTH-1:0] up_d [4];

  // Values for the FEED step about to be entered; registered on the edge.
  always_comb begin
    t_nxt = (state == CLEAR) ? 3'd0 : cnt + 3'd1;
    for (int r = 0; r < 4; r++) begin
      left_d[r] = '0;
      up_d[r]   = '0;
      for (int k = 0; k < 4; k++) begin
        if (int'(t_nxt) == r + k) begin
          left_d[r] = a_q[r*4+k];
          up_d[r]   = b_q[k*4+r];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      clr_o  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      if (state == IDLE && wr_en_i) begin
        if (wr_sel_i) b_q[wr_addr_i] <= wr_data_i;
        else          a_q[wr_addr_i] <= wr_data_i;
      end
      clr_o  <= 1'b0;
      done_o <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= CLEAR;
            clr_o  <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        CLEAR: begin
          state <= FEED;
          cnt   <= '0;
          left_q <= left_d;
          up_q   <= up_d;
        end
        FEED: begin
          if (cnt == 3'd6) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + 3'd1;
            left_q <= left_d;
            up_q   <= up_d;
          end
        end
        DRAIN: begin
          if (cnt == 3'd3) begin
            state  <= DONE;
            cnt    <= '0;
            done_o <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign left_o_0 = left_q[0];
  assign left_o_1 = left_q[1];
  assign left_o_2 = left_q[2];
  assign left_o_3 = left_q[3];
  assign up_o_0   = up_q[0];
  assign up_o_1   = up_q[1];
  assign up_o_2   = up_q[2];
  assign up_o_3   = up_q[3];

endmodule
